// File: rtl/button_pulse_conditioner.sv
// Push-button conditioner: normalise, synchronise, debounce, edge-detect, optional auto-repeat.
// Define AUTO_REPEAT_EN to build the repeat FSM; otherwise pb_step mirrors pb_down.
module button_pulse_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter bit          PB_ACTIVE_LOW   = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic PB,
    output logic pb_state,
    output logic pb_down,
    output logic pb_up,
    output logic pb_step
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          w_pb_norm;
    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_toggle;
    logic          w_state_nxt;
    logic          w_rise;
    logic          w_fall;
    logic          w_step_nxt;
    logic          r_pb_state;
    logic          r_pb_down;
    logic          r_pb_up;
    logic          r_pb_step;

    assign w_pb_norm = PB_ACTIVE_LOW ? ~PB : PB;

    always_comb begin
        w_cnt_nxt = '0;
        w_toggle  = 1'b0;
        if (r_sync2 != r_pb_state) begin
            if (r_cnt == CNT_LAST) begin
                w_toggle = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
    end

    assign w_state_nxt = r_pb_state ^ w_toggle;
    assign w_rise      = w_toggle & ~r_pb_state;
    assign w_fall      = w_toggle & r_pb_state;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

    rep_state_e    r_rep_state;
    rep_state_e    w_rep_state_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic          w_rep_pulse;

    // Looking at the next debounced level lets a same-edge release cancel a due repeat.
    always_comb begin
        w_rep_state_nxt = r_rep_state;
        w_timer_nxt     = r_timer;
        w_rep_pulse     = 1'b0;
        if (!w_state_nxt) begin
            w_rep_state_nxt = StIdle;
            w_timer_nxt     = '0;
        end else begin
            unique case (r_rep_state)
                StIdle: begin
                    if (w_rise) begin
                        w_rep_state_nxt = StDelay;
                        w_timer_nxt     = '0;
                    end
                end
                StDelay: begin
                    if (r_timer == DELAY_LAST) begin
                        w_rep_pulse     = 1'b1;
                        w_rep_state_nxt = StRepeat;
                        w_timer_nxt     = '0;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                StRepeat: begin
                    if (r_timer == PERIOD_LAST) begin
                        w_rep_pulse = 1'b1;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                default: begin
                    w_rep_state_nxt = StIdle;
                    w_timer_nxt     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rep_state <= StIdle;
            r_timer     <= '0;
        end else begin
            r_rep_state <= w_rep_state_nxt;
            r_timer     <= w_timer_nxt;
        end
    end

    assign w_step_nxt = w_rise | w_rep_pulse;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign w_step_nxt   = w_rise;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_cnt      <= '0;
            r_pb_state <= 1'b0;
            r_pb_down  <= 1'b0;
            r_pb_up    <= 1'b0;
            r_pb_step  <= 1'b0;
        end else begin
            r_sync1    <= w_pb_norm;
            r_sync2    <= r_sync1;
            r_cnt      <= w_cnt_nxt;
            r_pb_state <= w_state_nxt;
            r_pb_down  <= w_rise;
            r_pb_up    <= w_fall;
            r_pb_step  <= w_step_nxt;
        end
    end

    assign pb_state = r_pb_state;
    assign pb_down  = r_pb_down;
    assign pb_up    = r_pb_up;
    assign pb_step  = r_pb_step;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Randomised and directed bench for button_pulse_conditioner against a timing-rule model.
// Honours AUTO_REPEAT_EN the same way as the design.
module tb_button_pulse_conditioner;

    localparam int unsigned D  = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 5;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic PB = 1'b0;
    logic pb_state, pb_down, pb_up, pb_step;

    always #5 clock = ~clock;

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .PB_ACTIVE_LOW  (1'b1)
    ) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .PB      (PB),
        .pb_state(pb_state),
        .pb_down (pb_down),
        .pb_up   (pb_up),
        .pb_step (pb_step)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: pressed samples seen at the last edges, length of current disagreeing run,
    // and edges elapsed since the press was recognised (-1 when released).
    bit m_hist[2];
    int m_run   = 0;
    int m_since = -1;
    bit m_st, m_down, m_up, m_step;
    int step_cnt = 0;
    int ctr = 0;
    bit any_pulse = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit pb, input bit rst_n);
        bit synced, toggled, rep;
        if (!rst_n) begin
            m_hist[0] = 0; m_hist[1] = 0;
            m_run = 0; m_since = -1;
            m_st = 0; m_down = 0; m_up = 0; m_step = 0;
            return;
        end
        synced    = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = ~pb;
        toggled   = 1'b0;
        if (synced != m_st) m_run++;
        else                m_run = 0;
        if (m_run == int'(D)) begin
            m_st    = ~m_st;
            m_run   = 0;
            toggled = 1'b1;
        end
        m_down = toggled & m_st;
        m_up   = toggled & ~m_st;
        if (m_down)    m_since = 0;
        else if (m_st) m_since++;
        else           m_since = -1;
        rep = 1'b0;
`ifdef AUTO_REPEAT_EN
        if (m_st && !m_down && m_since >= int'(RD) && ((m_since - int'(RD)) % int'(RP)) == 0)
            rep = 1'b1;
`endif
        m_step = m_down | rep;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge(PB, reset_n);
        #1;
        check_eq("pb_state", pb_state, m_st);
        check_eq("pb_down", pb_down, m_down);
        check_eq("pb_up", pb_up, m_up);
        check_eq("pb_step", pb_step, m_step);
        if (pb_step) begin
            step_cnt++;
            ctr = (ctr == 3) ? 0 : ctr + 1;
        end
        if (pb_down || pb_up || pb_step) any_pulse = 1'b1;
    endtask

    task automatic hold(input bit pb, input int n);
        PB = pb;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_down(input string tag, input int limit, output int n);
        n = 0;
        PB = 1'b0;
        do begin
            tick();
            n++;
        end while (!pb_down && n < limit);
        if (!pb_down) check_eq({tag, "_timeout"}, 32'(n), 32'(limit + 1));
    endtask

    initial begin
        int n;
        int st0;
        // Reset with PB low (pressed) for 3 cycles, then one cycle free-running.
        reset_n = 1'b0;
        PB      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_out", {pb_state, pb_down, pb_up, pb_step}, 4'b0000);
        end
        reset_n = 1'b1;
        tick();
        check_eq("rst_after", {pb_state, pb_down, pb_up, pb_step}, 4'b0000);
        hold(1'b1, 12);

        // Clean press: pb_down seen on the (D+2)th tick after PB first drives low.
        wait_down("press", 20, n);
        check_eq("press_lat", 32'(n), 32'(D + 2));
        hold(1'b0, 3);
        st0 = step_cnt;
        hold(1'b1, 15);
        check_eq("release_nostep", 32'(step_cnt), 32'(st0));

        // Bounce every 2 cycles, then a 3-cycle glitch: nothing may emerge.
        any_pulse = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hold(1'b0, 2);
            hold(1'b1, 2);
        end
        hold(1'b1, 10);
        hold(1'b0, 3);
        hold(1'b1, 12);
        check_eq("bounce_quiet", 32'(any_pulse), 32'(0));

        // Long hold: release timed so the debounced release lands before the +45 repeat.
        step_cnt = 0;
        wait_down("hold", 20, n);
        hold(1'b0, 36);
        hold(1'b1, 20);
`ifdef AUTO_REPEAT_EN
        check_eq("hold_steps", 32'(step_cnt), 32'(8));
`else
        check_eq("hold_steps", 32'(step_cnt), 32'(1));
`endif

        // Reset on the edge a repeat would be due; held key re-presses after full debounce.
        wait_down("midhold", 20, n);
        hold(1'b0, RD - 1);
        st0 = step_cnt;
        any_pulse = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_eq("midrst_quiet", 32'(step_cnt), 32'(st0));
        wait_down("repress", 20, n);
        check_eq("repress_lat", 32'(n), 32'(D + 2));
        hold(1'b1, 12);

        // Wrap counter max=3 driven by pb_step over four short presses.
        ctr = 0;
        for (int i = 0; i < 4; i++) begin
            wait_down("ctr", 20, n);
            hold(1'b0, 3);
            hold(1'b1, 12);
            check_eq("wrap_ctr", 32'(ctr), 32'((i + 1) % 4));
        end

        // Random segments with occasional single-cycle resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
